tdm_slot_scheduler: RTL and testbench



---
 rtl/tdm_sched_pkg.sv | 18 +
 rtl/rr_next_picker.sv | 32 +++
 rtl/tdm_slot_scheduler.sv | 113 +++++++++++
 tb/tb_tdm_slot_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_sched_pkg.sv
// Shared types and helpers for the TDM slot scheduler.
// Build option: TDM_SKIP_IDLE_EN selects work-conserving scheduling (see tdm_slot_scheduler).
package tdm_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOT  = 2'd1,
        GUARD = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_next_picker.sv
// Round-robin search for the next channel after the last-served pointer.
// In strict mode every channel is treated as requesting, so a channel is always found.
module rr_next_picker
    import tdm_sched_pkg::*;
(
    input  logic [SEL_W-1:0]  i_ptr,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_mode_skip,
    output logic [SEL_W-1:0]  o_next,
    output logic              o_found
);

    logic [NUM_CH-1:0] w_req_eff;

    assign w_req_eff = i_mode_skip ? i_req : {NUM_CH{1'b1}};

    // Offset 4 wraps back to the pointer itself, so it is searched last.
    always_comb begin
        logic [SEL_W-1:0] v_idx;
        o_next  = '0;
        o_found = 1'b0;
        v_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            v_idx = i_ptr + SEL_W'(i);
            if (!o_found && w_req_eff[v_idx]) begin
                o_next  = v_idx;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_slot_scheduler.sv
// Round-robin TDM slot scheduler driving the 4:1 channel mux select and one-hot grant.
// Define TDM_SKIP_IDLE_EN for work-conserving mode; default is strict TDM.
//
//   state | meaning
//   IDLE  | no slot in progress, waiting for en (and a requester in skip mode)
//   SLOT  | grant high for the selected channel, counter running
//   GUARD | one dead cycle between slots, grant low, sel held
module tdm_slot_scheduler
    import tdm_sched_pkg::state_t, tdm_sched_pkg::IDLE, tdm_sched_pkg::SLOT,
           tdm_sched_pkg::GUARD, tdm_sched_pkg::SEL_W, tdm_sched_pkg::onehot4;
#(
    parameter int NUM_CH   = 4,
    parameter int SLOT_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant,
    output logic              slot_start,
    output logic              frame_start,
    output logic              busy
);

    localparam int             CW       = $clog2(SLOT_LEN + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SLOT_LEN - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_CH-1:0]  r_grant;
    logic               r_slot_start;
    logic               r_frame_start;
    logic               r_busy;

    logic [SEL_W-1:0]   w_next;
    logic               w_found;
    logic               w_early;
    logic               w_start;
    logic               w_mode_skip;

`ifdef TDM_SKIP_IDLE_EN
    assign w_mode_skip = 1'b1;
    assign w_early     = ~req[r_sel];
`else
    assign w_mode_skip = 1'b0;
    assign w_early     = 1'b0;
`endif

    rr_next_picker u_picker (
        .i_ptr       (r_ptr),
        .i_req       (req),
        .i_mode_skip (w_mode_skip),
        .o_next      (w_next),
        .o_found     (w_found)
    );

    // Decisions are only taken from IDLE or GUARD; en never cuts a running slot.
    assign w_start = ((r_state == IDLE) || (r_state == GUARD)) && en && w_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_ptr         <= SEL_W'(3);
            r_sel         <= '0;
            r_grant       <= '0;
            r_slot_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_slot_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_start) begin
                r_state       <= SLOT;
                r_sel         <= w_next;
                r_grant       <= onehot4(w_next);
                r_slot_start  <= 1'b1;
                r_frame_start <= (w_next == '0);
                r_cnt         <= '0;
                r_busy        <= 1'b1;
            end else begin
                case (r_state)
                    SLOT: begin
                        if ((r_cnt == CNT_LAST) || w_early) begin
                            r_state <= GUARD;
                            r_grant <= '0;
                            r_ptr   <= r_sel;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    GUARD: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sel         = r_sel;
    assign grant       = r_grant;
    assign slot_start  = r_slot_start;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Directed table-driven bench for tdm_slot_scheduler (strict build, or skip build with TDM_SKIP_IDLE_EN).
module tb_tdm_slot_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;

    logic [1:0] sel0, sel1;
    logic [3:0] grant0, grant1;
    logic       ss0, ss1, fs0, fs1, busy0, busy1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       en;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       ss;
        logic       fs;
        logic       busy;
    } vec_t;

    vec_t tbl[72];

    always #5 clk = ~clk;

    tdm_slot_scheduler #(.NUM_CH(4), .SLOT_LEN(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .sel(sel0), .grant(grant0), .slot_start(ss0), .frame_start(fs0), .busy(busy0)
    );

    tdm_slot_scheduler #(.NUM_CH(4), .SLOT_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .sel(sel1), .grant(grant1), .slot_start(ss1), .frame_start(fs1), .busy(busy1)
    );

    function automatic logic [8:0] obs0();
        return {sel0, grant0, ss0, fs0, busy0};
    endfunction

    function automatic logic [8:0] obs1();
        return {sel1, grant1, ss1, fs1, busy1};
    endfunction

    function automatic logic [8:0] mk(input int s, input logic [3:0] g, input logic ss,
                                      input logic fs, input logic b);
        return {2'(s), g, ss, fs, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic hit;
        int   ch_seq[4];
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        step();
        step();
        check("reset_dut8", 16'(obs0()), 16'(mk(0, 4'b0000, 0, 0, 0)));
        check("reset_dut1", 16'(obs1()), 16'(mk(0, 4'b0000, 0, 0, 0)));

`ifndef TDM_SKIP_IDLE_EN
        ch_seq = '{0, 1, 2, 3};
`else
        ch_seq = '{0, 2, 0, 2};
`endif
        // Two frames of 4 slots x (8 grant cycles + 1 guard).
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 4; c++)
                for (int k = 0; k <= 8; k++) begin
                    tbl[f*36 + c*9 + k].en    = 1'b1;
                    tbl[f*36 + c*9 + k].sel   = 2'(ch_seq[c]);
                    tbl[f*36 + c*9 + k].grant = (k < 8) ? 4'(1 << ch_seq[c]) : 4'b0000;
                    tbl[f*36 + c*9 + k].ss    = (k == 0);
                    tbl[f*36 + c*9 + k].fs    = (k == 0) && (ch_seq[c] == 0);
                    tbl[f*36 + c*9 + k].busy  = 1'b1;
                end

`ifndef TDM_SKIP_IDLE_EN
        req = 4'b0000;
`else
        req = 4'b0101;
`endif
        rst = 1'b0;
        for (int i = 0; i < 72; i++) begin
            en = tbl[i].en;
            step();
            check($sformatf("table_%0d", i), 16'(obs0()),
                  16'({tbl[i].sel, tbl[i].grant, tbl[i].ss, tbl[i].fs, tbl[i].busy}));
        end

`ifndef TDM_SKIP_IDLE_EN
        // en dropped in the second cycle of channel 2's slot.
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            step();
            if (sel0 == 2'd2 && ss0) hit = 1'b1;
        end
        check("wait_ch2_slot", 16'(hit), 16'd1);
        step();
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("en_drop_slot_%0d", k), 16'(grant0), 16'b0100);
        end
        step();
        check("en_drop_guard", 16'(obs0()), 16'(mk(2, 4'b0000, 0, 0, 1)));
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("en_drop_idle_%0d", k), 16'(obs0()), 16'(mk(2, 4'b0000, 0, 0, 0)));
        end
        en = 1'b1;
        step();
        check("en_return_ch3", 16'(obs0()), 16'(mk(3, 4'b1000, 1, 0, 1)));

        // Reset mid-slot, then restart with channel 0.
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("mid_rst_dut8", 16'(obs0()), 16'(mk(0, 4'b0000, 0, 0, 0)));
        check("mid_rst_dut1", 16'(obs1()), 16'(mk(0, 4'b0000, 0, 0, 0)));
        step();
        rst = 1'b0;
        step();
        check("post_rst_dut8", 16'(obs0()), 16'(mk(0, 4'b0001, 1, 1, 1)));
        check("post_rst_dut1", 16'(obs1()), 16'(mk(0, 4'b0001, 1, 1, 1)));
        // SLOT_LEN=1: grant alternates one-hot / zero, frame of 8 cycles.
        for (int k = 1; k < 16; k++) begin
            step();
            check($sformatf("len1_%0d", k), 16'(obs1()),
                  16'(mk((k/2) % 4, (k % 2 == 0) ? 4'(1 << ((k/2) % 4)) : 4'b0000,
                         (k % 2 == 0), (k % 8 == 0), 1'b1)));
        end
`else
        // req[1] drops in the third cycle of its slot: slot ends on the next edge.
        rst = 1'b1;
        req = 4'b0010;
        step();
        step();
        rst = 1'b0;
        step();
        check("early_slot_start", 16'(obs0()), 16'(mk(1, 4'b0010, 1, 0, 1)));
        step();
        check("early_cyc2", 16'(grant0), 16'b0010);
        step();
        check("early_cyc3", 16'(grant0), 16'b0010);
        req = 4'b0100;
        step();
        check("early_guard", 16'(obs0()), 16'(mk(1, 4'b0000, 0, 0, 1)));
        step();
        check("early_next_ch2", 16'(obs0()), 16'(mk(2, 4'b0100, 1, 0, 1)));
        hit = 1'b0;
        req = 4'b0000;
        for (int n = 0; n < 10; n++) begin
            step();
            if (busy0) hit = 1'b1;
        end
        check("no_req_idle", 16'(busy0), 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
